// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between I-cache fills and D-cache fills/write-backs.
// D has fixed priority; starve_cnt forces an I grant after STARVE_LIMIT D grants while I waits.
//
// state | meaning
// IDLE  | no grant, arbitrating pending requests
// GNT_I | I-cache line fill owns the memory port
// GNT_D | D-cache fill or write-back owns the memory port
module mem_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       starved;

  assign d_req   = d_mem_read | d_mem_write;
  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_mem_read && (!d_req || starved)) begin
          grant_i   = 1'b1;
          state_nxt = GNT_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory-side strobes and payload are only loaded on a grant, so they stay frozen for its duration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_i) begin
      mem_read  <= 1'b1;
      mem_write <= 1'b0;
      mem_addr  <= i_mem_addr;
      mem_wdata <= '0;
    end else if (grant_d) begin
      mem_read  <= d_mem_read;
      mem_write <= d_mem_write;
      mem_addr  <= d_mem_addr;
      mem_wdata <= d_mem_wdata;
    end else if (state != IDLE && mem_ready) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (grant_i) begin
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      if (!i_mem_read)  starve_cnt <= 4'd0;
      else if (!starved) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign i_mem_ready = (state == GNT_I) && mem_ready;
  assign d_mem_ready = (state == GNT_D) && mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/write-back path of the pipelined RISC-V core.
- Sits between both cache controllers and the memory model.
- Grants one whole transaction at a time and holds the grant until memory returns mem_ready.
- D-side has fixed priority, with a starvation limit that guarantees instruction fetch progress.

Parameters:
- ADDR_W, 28, block address width (word address >> 2)
- DATA_W, 128, cache line width
- STARVE_LIMIT, 4, consecutive D grants tolerated while an I request waits; range 1..15

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- i_mem_read  input  1  I-cache line-fill request; held high until i_mem_ready
- i_mem_addr  input  ADDR_W  I-cache block address
- i_mem_rdata  output  DATA_W  fill data to I-cache
- i_mem_ready  output  1  I transaction complete, one-cycle pulse
- d_mem_read  input  1  D-cache line-fill request
- d_mem_write  input  1  D-cache write-back request; never high together with d_mem_read
- d_mem_addr  input  ADDR_W  D-cache block address
- d_mem_wdata  input  DATA_W  write-back line
- d_mem_rdata  output  DATA_W  fill data to D-cache
- d_mem_ready  output  1  D transaction complete, one-cycle pulse
- mem_read  output  1  memory read strobe, registered
- mem_write  output  1  memory write strobe, registered
- mem_addr  output  ADDR_W  memory address, registered
- mem_wdata  output  DATA_W  memory write data, registered
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- mem_ready  input  1  memory transaction complete

Behaviour:
- Reset values (rst_n low at posedge):
  - state=IDLE, starve_cnt=0.
  - mem_read, mem_write = 0; mem_addr, mem_wdata = 0.
  - i_mem_ready, d_mem_ready = 0.
- Reset mid-transaction aborts: next cycle all strobes are 0 and state is IDLE. Memory-side cleanup is the memory model's concern.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE, at the posedge where a request is seen:
  - Only I requests -> GNT_I.
  - Only D (read or write) requests -> GNT_D.
  - Both request -> GNT_I if starve_cnt == STARVE_LIMIT, else GNT_D.
  - No request -> stay in IDLE.
  - mem_ready while in IDLE is ignored and produces no ready pulse.
- On entering GNT_x: mem_addr and mem_wdata are latched from the winner. mem_read or mem_write is asserted from the first GNT cycle (1-cycle grant latency after the request is sampled). Strobe and address stay constant for the whole grant.
- In GNT_x with mem_ready=1:
  - x_mem_ready=1 combinationally in that same cycle.
  - x_mem_rdata=mem_rdata.
  - Next state is IDLE and the strobes deassert at that edge.
- The served cache drops its request at the same edge. IDLE therefore never re-grants a stale request.
- Every transaction has a minimum of 2 cycles between back-to-back grants: an IDLE cycle always separates them.
- Non-granted ready output is held 0. Both rdata outputs are driven from mem_rdata at all times; consumers qualify them with their ready.
- starve_cnt (4-bit):
  - On a D grant while i_mem_read=1: increment, saturating at STARVE_LIMIT.
  - On any I grant: clear to 0.
  - On a D grant with no I pending: clear to 0.
- Requests that change while granted (protocol violation) are ignored until IDLE.
- A D write-back followed by a D refill is two transactions; a starved I may win the slot between them.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all requests high -> all mem_* outputs 0 and both ready outputs 0; on release, the first grant goes to D.
- Single I fill: i_mem_read=1 with addr=0x0000010; memory returns ready after 5 cycles with rdata=0xDEADBEEF_...
  - mem_read=1 and mem_addr=0x0000010 from cycle+1.
  - i_mem_ready pulses once carrying that data; d_mem_ready stays 0.
- Simultaneous I and D read, starve_cnt=0 -> D is served first; I is granted in the IDLE cycle after d_mem_ready and finishes second.
- D write-back: d_mem_write=1 with wdata=0x1234..., addr=0x00000A0 -> mem_write=1, mem_wdata and mem_addr match and stay stable until mem_ready; mem_read stays 0.
- Starvation: I held high while D issues back-to-back requests, STARVE_LIMIT=4 -> exactly 4 D grants, then I granted even though D is pending; starve_cnt returns to 0.
- rst_n asserted in the middle of GNT_D, then mem_ready arrives late -> arbiter stays in IDLE and no d_mem_ready pulse occurs.
